ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter that sends command bytes to the keyboard, e.g. 0xED set LEDs, 0xFF reset, 0xF4 enable.
- Runs the request-to-send sequence, shifts out an 11-bit frame on device-generated clock edges and checks the device ACK.
- Sits beside the keyboard receive path and drives the shared PS/2 clock/data lines through open-drain enables.
- ps2_clk_in and ps2_data_in come from the design's synchronized/debounced line inputs.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before RTS (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: max clk cycles between consecutive device clock falling edges (15 ms at 50 MHz).
- CNT_WIDTH, 20: timer width; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  command byte
- tx_ready  out  1  high in IDLE; a transfer is accepted when tx_valid & tx_ready
- busy  out  1  high in any state other than IDLE
- ps2_clk_in  in  1  synchronized PS/2 clock line level
- ps2_data_in  in  1  synchronized PS/2 data line level
- ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
- ps2_data_oe  out  1  1 = pull PS/2 data low, 0 = release
- done  out  1  one-cycle pulse: frame sent and ACKed
- err_nack  out  1  one-cycle pulse: no ACK from device
- err_timeout  out  1  one-cycle pulse: device clock timeout

Behaviour:
- Reset:
  - state = IDLE; tx_ready = 1; busy = 0; all other outputs 0.
  - Both lines are released immediately (asynchronous), including when reset hits mid-frame.
- All outputs are registered.
- Falling-edge detect: fall = clk_prev & ~ps2_clk_in, where clk_prev is a one-flop history of ps2_clk_in.
- IDLE:
  - On tx_valid & tx_ready, latch frame = {stop = 1, parity = ~^tx_data, tx_data}.
  - Next cycle: state = INHIBIT, ps2_clk_oe = 1, timer = 0.
  - tx_valid while not ready is ignored; nothing is queued.
- INHIBIT:
  - Hold ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles.
  - On the final cycle, set ps2_data_oe = 1 (start bit 0).
  - Next cycle: ps2_clk_oe = 0, state = RTS, timer = 0, edge_cnt = 0.
- RTS/SHIFT:
  - The timer restarts on every fall.
  - On fall k (k = 1..10), ps2_data_oe = ~frame[k-1] from the next cycle:
    - k = 1..8: data LSB first.
    - k = 9: parity.
    - k = 10: stop bit (line released).
  - After fall 10: state = ACK.
- ACK:
  - On fall 11, sample ps2_data_in.
  - 0: state = WAIT_IDLE.
  - 1: pulse err_nack, return to IDLE; lines are already released.
- WAIT_IDLE:
  - Wait until ps2_clk_in = 1 and ps2_data_in = 1 in the same cycle.
  - Then pulse done and go to IDLE; tx_ready rises in that same cycle.
  - The same timeout check applies here.
- Timeout:
  - Applies in RTS, SHIFT, ACK and WAIT_IDLE.
  - When timer reaches TIMEOUT_CYCLES with no qualifying event: ps2_clk_oe = 0 and ps2_data_oe = 0, pulse err_timeout, go to IDLE.
- Exclusivity: done, err_nack and err_timeout are mutually exclusive, and exactly one fires per accepted request.
- Timer arithmetic: saturating at TIMEOUT_CYCLES, never wraps. edge_cnt is 4 bits and never exceeds 11.
- Glitch rule: a fall during INHIBIT (the device sees the host holding clk low) is ignored.
- Back-to-back: a new request can be accepted on the cycle after done or an err_* pulse.

Decomposition:
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
  - Frame constants: FRAME_BITS = 10 driven, ACK_EDGE = 11.
  - Command constants: CMD_SET_LED 0xED, CMD_RESET 0xFF, CMD_ENABLE 0xF4, CMD_ECHO 0xEE.
- Sub-module: ps2_fall_det (one-flop history, one-cycle fall pulse). It is reusable by the receive path.

Test Plan:
All scenarios use INHIBIT_CYCLES = 8 and TIMEOUT_CYCLES = 64. The bench device model toggles ps2_clk every 20 clk.
- Send 0xED:
  - Required: ps2_clk_oe high exactly 8 cycles, then data_oe = 1.
  - Bits after falls 1..8 are 1,0,1,1,0,1,1,1; parity 1; stop released.
  - Model ACKs low on fall 11, then releases: one done pulse, no err_*, tx_ready = 1.
- Send 0x01:
  - Required: parity bit (after fall 9) = 0.
  - Send 0x00: parity = 1. Both end in done.
- NACK: model leaves data high at fall 11 -> err_nack pulse, both oe = 0, state IDLE, no done.
- Timeout: model never clocks after RTS -> err_timeout exactly 64 cycles after RTS entry, both oe = 0.
- Busy and reset:
  - tx_valid with 0x55 during SHIFT of 0xF4 is ignored; 0xF4 is sent intact.
  - rst_n low after fall 5 -> both oe = 0 that same cycle, tx_ready = 1 after release; a following 0xFF sends correctly.
- Back-to-back: 0xED then 0x07 with tx_valid held -> second INHIBIT starts the cycle after the first done; both frames are correct.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host/device interface.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned ACK_EDGE   = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;

    // Host-driven part of a frame, LSB first after the start bit: data, odd parity, stop.
    function automatic logic [9:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_fall_det.sv
// Falling-edge detector for a synchronized PS/2 line: one-cycle pulse on 1->0.
module ps2_fall_det (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic fall
);

    logic prev;

    // History resets high so an idle (released) line never produces a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= line_in;
    end

    assign fall = prev & ~line_in;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10 driven bits, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned CNT_WIDTH      = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       err_nack,
    output logic       err_timeout
);

    localparam logic [CNT_WIDTH-1:0] INH_LAST = CNT_WIDTH'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_MAX   = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [3:0]           LAST_BIT = 4'(FRAME_BITS - 1);

    ps2_state_t           state;
    logic [9:0]           frame;
    logic [CNT_WIDTH-1:0] timer;
    logic [CNT_WIDTH-1:0] timer_inc;
    logic [3:0]           edge_cnt;
    logic                 fall;
    logic                 evt;
    logic                 timed_out;
    logic                 data_pre;

    ps2_fall_det u_fall_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_clk_in),
        .fall    (fall)
    );

    always_comb begin
        evt       = (state == WAIT_IDLE) ? (ps2_clk_in & ps2_data_in) : fall;
        timer_inc = (timer == TO_MAX) ? timer : timer + 1'b1;
        timed_out = (timer >= TO_LAST);
        // Data goes low one cycle before the clock is released so the start bit is stable.
        data_pre  = (32'(timer) + 32'd2 >= INHIBIT_CYCLES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame       <= '0;
            timer       <= '0;
            edge_cnt    <= '0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        frame      <= ps2_frame(tx_data);
                        state      <= INHIBIT;
                        ps2_clk_oe <= 1'b1;
                        timer      <= '0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                INHIBIT: begin
                    timer <= timer + 1'b1;
                    if (data_pre) ps2_data_oe <= 1'b1;
                    if (timer == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        state      <= RTS;
                        timer      <= '0;
                        edge_cnt   <= '0;
                    end
                end
                RTS, SHIFT, ACK, WAIT_IDLE: begin
                    if (evt) begin
                        timer <= '0;
                        case (state)
                            RTS: begin
                                ps2_data_oe <= ~frame[0];
                                edge_cnt    <= 4'd1;
                                state       <= SHIFT;
                            end
                            SHIFT: begin
                                ps2_data_oe <= ~frame[edge_cnt];
                                edge_cnt    <= edge_cnt + 1'b1;
                                if (edge_cnt == LAST_BIT) state <= ACK;
                            end
                            ACK: begin
                                edge_cnt <= 4'(ACK_EDGE);
                                if (!ps2_data_in) begin
                                    state <= WAIT_IDLE;
                                end else begin
                                    err_nack <= 1'b1;
                                    state    <= IDLE;
                                    tx_ready <= 1'b1;
                                    busy     <= 1'b0;
                                end
                            end
                            default: begin
                                done     <= 1'b1;
                                state    <= IDLE;
                                tx_ready <= 1'b1;
                                busy     <= 1'b0;
                            end
                        endcase
                    end else if (timed_out) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed + randomized bench for ps2_host_tx against a simple PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 8;
    localparam int unsigned TO  = 64;
    localparam int R_NONE = 0, R_DONE = 1, R_NACK = 2, R_TO = 3, R_ABORT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err_nack, err_timeout;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int checks = 0, errors = 0;
    int n_done = 0, n_nack = 0, n_to = 0;
    int exp_done = 0, exp_nack = 0, exp_to = 0;

    // Open-drain wired-AND of host and device on each line.
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(20)) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .busy(busy), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .done(done),
        .err_nack(err_nack), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)        n_done++;
        if (err_nack)    n_nack++;
        if (err_timeout) n_to++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level the device should see after fall k (1..10): data LSB first, odd parity, stop.
    function automatic logic ref_bit(input logic [7:0] b, input int k);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        if (k <= 8) return b[k-1];
        if (k == 9) return (ones % 2 == 0);
        return 1'b1;
    endfunction

    task automatic start_req(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
    endtask

    task automatic inhibit_check(input bit drop, input logic [7:0] next_data);
        int n = 0;
        bit fin = 0;
        for (int c = 0; c < 50 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("busy_after_accept", busy, 1);
                if (drop) tx_valid = 1'b0;
                tx_data = next_data;
            end
            if (ps2_clk_oe) n++;
            else fin = 1;
        end
        chk("inhibit_len", n, INH);
        chk("rts_data_oe", ps2_data_oe, 1);
    endtask

    task automatic device_frame(input logic [7:0] b, input bit ack, input int abort_k,
                                input int inject_k, output int res);
        res = R_NONE;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_data = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b0;
            if (k <= 10) begin
                repeat (10) @(negedge clk);
                chk($sformatf("bit%0d_of_%0h", k, b), ps2_data_oe, !ref_bit(b, k));
                if (k == inject_k) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'h55;
                    chk("ready_low_in_shift", tx_ready, 0);
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
                if (k == abort_k) begin
                    rst_n = 1'b0;
                    #1;
                    chk("reset_clk_oe", ps2_clk_oe, 0);
                    chk("reset_data_oe", ps2_data_oe, 0);
                    dev_clk = 1'b1;
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk("reset_tx_ready", tx_ready, 1);
                    chk("reset_busy", busy, 0);
                    res = R_ABORT;
                    return;
                end
                repeat (10) @(negedge clk);
                dev_clk = 1'b1;
            end else begin
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    if (done || err_nack || err_timeout) begin
                        res = done ? R_DONE : (err_nack ? R_NACK : R_TO);
                        chk("one_pulse", int'(done) + int'(err_nack) + int'(err_timeout), 1);
                        chk("end_tx_ready", tx_ready, 1);
                        chk("end_busy", busy, 0);
                        chk("end_clk_oe", ps2_clk_oe, 0);
                        chk("end_data_oe", ps2_data_oe, 0);
                        break;
                    end
                    if (c == 19) begin
                        dev_clk  = 1'b1;
                        dev_data = 1'b1;
                    end
                end
                if (dev_clk == 1'b0) begin
                    repeat (19) @(negedge clk);
                    dev_clk  = 1'b1;
                    dev_data = 1'b1;
                end
            end
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        chk("count_done", n_done, exp_done);
        chk("count_nack", n_nack, exp_nack);
        chk("count_timeout", n_to, exp_to);
    endtask

    task automatic send(input logic [7:0] b, input bit ack);
        int res;
        start_req(b);
        inhibit_check(1, b);
        device_frame(b, ack, 0, 0, res);
        chk($sformatf("result_%0h", b), res, ack ? R_DONE : R_NACK);
        if (ack) exp_done++;
        else     exp_nack++;
        settle();
    endtask

    initial begin
        int res;
        int c;
        logic [7:0] rb;
        bit rack;

        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_pulses", {29'd0, done, err_nack, err_timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(CMD_SET_LED, 1);
        send(8'h01, 1);
        send(8'h00, 1);
        send(CMD_ECHO, 0);

        // Device never clocks: timeout counted from the first cycle of RTS.
        start_req(8'h3C);
        inhibit_check(1, 8'h3C);
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (err_timeout) break;
        end
        chk("timeout_cycles", c, TO);
        chk("timeout_clk_oe", ps2_clk_oe, 0);
        chk("timeout_data_oe", ps2_data_oe, 0);
        chk("timeout_tx_ready", tx_ready, 1);
        exp_to++;
        settle();

        // A request while busy is dropped and must not disturb the frame in flight.
        start_req(CMD_ENABLE);
        inhibit_check(1, CMD_ENABLE);
        device_frame(CMD_ENABLE, 1, 0, 3, res);
        chk("result_busy_ignore", res, R_DONE);
        exp_done++;
        settle();
        repeat (4) @(negedge clk);
        chk("nothing_queued_clk_oe", ps2_clk_oe, 0);
        chk("nothing_queued_busy", busy, 0);

        start_req(8'hA5);
        inhibit_check(1, 8'hA5);
        device_frame(8'hA5, 1, 5, 0, res);
        chk("result_abort", res, R_ABORT);
        settle();
        send(CMD_RESET, 1);

        // Back-to-back with tx_valid held; tx_data changes after the first accept.
        start_req(CMD_SET_LED);
        inhibit_check(0, 8'h07);
        device_frame(CMD_SET_LED, 1, 0, 0, res);
        chk("result_b2b_first", res, R_DONE);
        exp_done++;
        inhibit_check(1, 8'h07);
        device_frame(8'h07, 1, 0, 0, res);
        chk("result_b2b_second", res, R_DONE);
        exp_done++;
        settle();

        for (int i = 0; i < 6; i++) begin
            rb   = 8'($urandom);
            rack = ($urandom_range(0, 3) != 0);
            send(rb, rack);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
